// File: rtl/branch_resolver.sv
// Execute-side resolver for BEQ/JR/J: checks the fetch prediction, redirects fetch and
// squashes younger work for FLUSH_CYCLES cycles after a wrong path; keeps saturating stats.
module branch_resolver #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk_x70,
   input  logic             rst_n_x70,
   input  logic             valid_in_x70,
   output logic             ready_x70,
   input  logic [2:0]       inst_type_x70,
   input  logic             predicted_x70,
   input  logic [31:0]      pc_x70,
   input  logic [31:0]      imm_x70,
   input  logic [31:0]      src1_val_x70,
   input  logic [31:0]      src2_val_x70,
   output logic             mispredict_x70,
   output logic [31:0]      redirect_pc_x70,
   output logic             flush_x70,
   output logic             resolved_valid_x70,
   output logic             resolved_taken_x70,
   output logic [CNT_W-1:0] branch_count_x70,
   output logic [CNT_W-1:0] mispredict_count_x70
);

   // state | meaning
   // IDLE  | accepting one instruction per cycle, resolving E1
   // FLUSH | squashing younger stages, inputs dropped, counter running down
   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [2:0] TYPE_BEQ = 3'd5;
   localparam logic [2:0] TYPE_JR  = 3'd6;
   localparam logic [2:0] TYPE_J   = 3'd7;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [3:0]        flush_cnt_q, flush_cnt_d;

   logic              e1_valid_q;
   logic [2:0]        e1_type_q;
   logic              e1_pred_q;
   logic [31:0]       e1_pc_q, e1_imm_q, e1_src1_q, e1_src2_q;

   logic              mispredict_q, resolved_valid_q, resolved_taken_q;
   logic [31:0]       redirect_pc_q;
   logic [CNT_W-1:0]  branch_count_q, branch_count_d;
   logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

   logic              is_beq, is_jr, is_j, is_ctrl, beq_taken;
   logic              res_taken, res_mis, accept;
   logic [31:0]       target, fallthrough, redirect;

   always_comb begin
      is_beq      = e1_type_q == TYPE_BEQ;
      is_jr       = e1_type_q == TYPE_JR;
      is_j        = e1_type_q == TYPE_J;
      is_ctrl     = e1_valid_q & (is_beq | is_jr | is_j);
      beq_taken   = e1_src1_q == e1_src2_q;
      fallthrough = e1_pc_q + 32'd4;
      target      = fallthrough + {e1_imm_q[29:0], 2'b00};
      res_taken   = is_jr | is_j | (is_beq & beq_taken);
      res_mis     = is_ctrl & (is_jr | (is_beq & (beq_taken != e1_pred_q)));
      if (is_jr)
         redirect = {e1_src1_q[31:2], 2'b00};
      else if (beq_taken)
         redirect = target;
      else
         redirect = fallthrough;
      // The instruction arriving alongside a resolving mispredict is younger, so squash it.
      accept = valid_in_x70 & (state_q == IDLE) & ~res_mis;
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE: begin
            if (res_mis) begin
               state_d     = FLUSH;
               flush_cnt_d = 4'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (flush_cnt_q <= 4'd1) begin
               state_d     = IDLE;
               flush_cnt_d = 4'd0;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            flush_cnt_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (is_ctrl && (branch_count_q != {CNT_W{1'b1}}))
         branch_count_d = branch_count_q + CNT_ONE;
      if (res_mis && (mispredict_count_q != {CNT_W{1'b1}}))
         mispredict_count_d = mispredict_count_q + CNT_ONE;
   end

   always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
      if (!rst_n_x70) begin
         state_q            <= IDLE;
         flush_cnt_q        <= 4'd0;
         e1_valid_q         <= 1'b0;
         e1_type_q          <= 3'd0;
         e1_pred_q          <= 1'b0;
         e1_pc_q            <= 32'd0;
         e1_imm_q           <= 32'd0;
         e1_src1_q          <= 32'd0;
         e1_src2_q          <= 32'd0;
         mispredict_q       <= 1'b0;
         redirect_pc_q      <= 32'd0;
         resolved_valid_q   <= 1'b0;
         resolved_taken_q   <= 1'b0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         flush_cnt_q        <= flush_cnt_d;
         e1_valid_q         <= accept;
         if (accept) begin
            e1_type_q <= inst_type_x70;
            e1_pred_q <= predicted_x70;
            e1_pc_q   <= pc_x70;
            e1_imm_q  <= imm_x70;
            e1_src1_q <= src1_val_x70;
            e1_src2_q <= src2_val_x70;
         end
         mispredict_q       <= res_mis;
         if (res_mis)
            redirect_pc_q <= redirect;
         resolved_valid_q   <= is_ctrl;
         resolved_taken_q   <= is_ctrl & res_taken;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign ready_x70            = (state_q == IDLE);
   assign flush_x70            = (state_q == FLUSH);
   assign mispredict_x70       = mispredict_q;
   assign redirect_pc_x70      = redirect_pc_q;
   assign resolved_valid_x70   = resolved_valid_q;
   assign resolved_taken_x70   = resolved_taken_q;
   assign branch_count_x70     = branch_count_q;
   assign mispredict_count_x70 = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver; a second instance with 4-bit counters checks saturation.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [2:0]  inst_type;
   logic        predicted;
   logic [31:0] pc, imm, src1, src2;

   logic        ready, mispredict, flush, rvalid, rtaken;
   logic [31:0] redirect;
   logic [15:0] bcnt, mcnt;

   logic        s_ready, s_mispredict, s_flush, s_rvalid, s_rtaken;
   logic [31:0] s_redirect;
   logic [3:0]  s_bcnt, s_mcnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk_x70(clk), .rst_n_x70(rst_n), .valid_in_x70(valid_in), .ready_x70(ready),
      .inst_type_x70(inst_type), .predicted_x70(predicted), .pc_x70(pc), .imm_x70(imm),
      .src1_val_x70(src1), .src2_val_x70(src2), .mispredict_x70(mispredict),
      .redirect_pc_x70(redirect), .flush_x70(flush), .resolved_valid_x70(rvalid),
      .resolved_taken_x70(rtaken), .branch_count_x70(bcnt), .mispredict_count_x70(mcnt)
   );

   branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
      .clk_x70(clk), .rst_n_x70(rst_n), .valid_in_x70(valid_in), .ready_x70(s_ready),
      .inst_type_x70(inst_type), .predicted_x70(predicted), .pc_x70(pc), .imm_x70(imm),
      .src1_val_x70(src1), .src2_val_x70(src2), .mispredict_x70(s_mispredict),
      .redirect_pc_x70(s_redirect), .flush_x70(s_flush), .resolved_valid_x70(s_rvalid),
      .resolved_taken_x70(s_rtaken), .branch_count_x70(s_bcnt), .mispredict_count_x70(s_mcnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic drive(input logic [2:0] t, input logic p, input logic [31:0] a,
                        input logic [31:0] i, input logic [31:0] s1, input logic [31:0] s2);
      valid_in  = 1'b1;
      inst_type = t;
      predicted = p;
      pc        = a;
      imm       = i;
      src1      = s1;
      src2      = s2;
   endtask

   initial begin
      rst_n = 1'b1;
      drive(3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_mis", 32'(mispredict), 32'd0);
      check("rst_redirect", redirect, 32'd0);
      check("rst_bcnt", 32'(bcnt), 32'd0);
      do_reset();

      // 1: BEQ taken, predicted not-taken -> redirect to target 8+4+12
      drive(3'd5, 1'b0, 32'd8, 32'd3, 32'd5, 32'd5);
      step();
      valid_in = 1'b0;
      check("t1_no_early_mis", 32'(mispredict), 32'd0);
      step();
      check("t1_mis", 32'(mispredict), 32'd1);
      check("t1_redirect", redirect, 32'd24);
      check("t1_rvalid", 32'(rvalid), 32'd1);
      check("t1_rtaken", 32'(rtaken), 32'd1);
      check("t1_flush_c1", 32'(flush), 32'd1);
      check("t1_ready_c1", 32'(ready), 32'd0);
      check("t1_bcnt", 32'(bcnt), 32'd1);
      check("t1_mcnt", 32'(mcnt), 32'd1);
      step();
      check("t1_mis_pulse", 32'(mispredict), 32'd0);
      check("t1_rvalid_pulse", 32'(rvalid), 32'd0);
      check("t1_flush_c2", 32'(flush), 32'd1);
      check("t1_ready_c2", 32'(ready), 32'd0);
      step();
      check("t1_flush_end", 32'(flush), 32'd0);
      check("t1_ready_end", 32'(ready), 32'd1);

      // 2: BEQ not taken, predicted taken -> fallthrough 24; then same pc/imm taken -> 16
      drive(3'd5, 1'b1, 32'd20, 32'hFFFF_FFFE, 32'd1, 32'd2);
      step();
      valid_in = 1'b0;
      step();
      check("t2_mis", 32'(mispredict), 32'd1);
      check("t2_redirect", redirect, 32'd24);
      check("t2_rtaken", 32'(rtaken), 32'd0);
      step();
      step();
      drive(3'd5, 1'b0, 32'd20, 32'hFFFF_FFFE, 32'd7, 32'd7);
      step();
      valid_in = 1'b0;
      step();
      check("t2_target_mis", 32'(mispredict), 32'd1);
      check("t2_target", redirect, 32'd16);
      check("t2_bcnt", 32'(bcnt), 32'd3);
      check("t2_mcnt", 32'(mcnt), 32'd3);
      step();
      step();

      // 3: four correctly predicted BEQs back to back
      do_reset();
      drive(3'd5, 1'b1, 32'h100, 32'd1, 32'd9, 32'd9);
      step();
      drive(3'd5, 1'b0, 32'h104, 32'd1, 32'd1, 32'd2);
      step();
      check("t3_rv0", 32'(rvalid), 32'd1);
      check("t3_rt0", 32'(rtaken), 32'd1);
      drive(3'd5, 1'b1, 32'h108, 32'd1, 32'd0, 32'd0);
      step();
      check("t3_rv1", 32'(rvalid), 32'd1);
      check("t3_rt1", 32'(rtaken), 32'd0);
      check("t3_mis1", 32'(mispredict), 32'd0);
      drive(3'd5, 1'b0, 32'h10C, 32'd1, 32'd3, 32'd4);
      step();
      check("t3_rv2", 32'(rvalid), 32'd1);
      check("t3_rt2", 32'(rtaken), 32'd1);
      check("t3_ready2", 32'(ready), 32'd1);
      valid_in = 1'b0;
      step();
      check("t3_rv3", 32'(rvalid), 32'd1);
      check("t3_rt3", 32'(rtaken), 32'd0);
      check("t3_mis3", 32'(mispredict), 32'd0);
      check("t3_bcnt", 32'(bcnt), 32'd4);
      check("t3_mcnt", 32'(mcnt), 32'd0);
      check("t3_ready", 32'(ready), 32'd1);
      step();
      check("t3_rv_idle", 32'(rvalid), 32'd0);

      // 4: JR always mispredicts; the J behind it is squashed until ready returns
      do_reset();
      drive(3'd6, 1'b0, 32'h200, 32'd0, 32'h0000_003F, 32'd0);
      step();
      drive(3'd7, 1'b0, 32'h204, 32'd0, 32'd0, 32'd0);
      step();
      check("t4_jr_mis", 32'(mispredict), 32'd1);
      check("t4_jr_redirect", redirect, 32'h0000_003C);
      check("t4_jr_rtaken", 32'(rtaken), 32'd1);
      step();
      check("t4_j_dropped_rv", 32'(rvalid), 32'd0);
      check("t4_bcnt_drop", 32'(bcnt), 32'd1);
      step();
      check("t4_j_dropped_rv2", 32'(rvalid), 32'd0);
      check("t4_ready_back", 32'(ready), 32'd1);
      step();
      valid_in = 1'b0;
      step();
      check("t4_j_rv", 32'(rvalid), 32'd1);
      check("t4_j_rtaken", 32'(rtaken), 32'd1);
      check("t4_j_no_mis", 32'(mispredict), 32'd0);
      check("t4_bcnt", 32'(bcnt), 32'd2);
      check("t4_mcnt", 32'(mcnt), 32'd1);

      // 5: asynchronous reset in the middle of a flush
      drive(3'd5, 1'b1, 32'h300, 32'd2, 32'd1, 32'd0);
      step();
      valid_in = 1'b0;
      step();
      check("t5_mis", 32'(mispredict), 32'd1);
      check("t5_flush", 32'(flush), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_flush", 32'(flush), 32'd0);
      check("t5_async_ready", 32'(ready), 32'd1);
      check("t5_async_mis", 32'(mispredict), 32'd0);
      check("t5_async_bcnt", 32'(bcnt), 32'd0);
      check("t5_async_mcnt", 32'(mcnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'd5, 1'b1, 32'h400, 32'd1, 32'd6, 32'd6);
      step();
      valid_in = 1'b0;
      step();
      check("t5_fresh_rv", 32'(rvalid), 32'd1);
      check("t5_fresh_mis", 32'(mispredict), 32'd0);
      check("t5_fresh_bcnt", 32'(bcnt), 32'd1);

      // 6: 17 spaced mispredicting JRs saturate 4-bit counters
      do_reset();
      for (int n = 0; n < 17; n++) begin
         drive(3'd6, 1'b0, 32'h500, 32'd0, 32'h80, 32'd0);
         step();
         valid_in = 1'b0;
         step();
         step();
         step();
         if (n == 13) begin
            check("t6_sat_mcnt_14", 32'(s_mcnt), 32'd14);
            check("t6_sat_bcnt_14", 32'(s_bcnt), 32'd14);
         end
      end
      check("t6_sat_mcnt", 32'(s_mcnt), 32'd15);
      check("t6_sat_bcnt", 32'(s_bcnt), 32'd15);
      check("t6_wide_mcnt", 32'(mcnt), 32'd17);
      check("t6_wide_bcnt", 32'(bcnt), 32'd17);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Execute-side counterpart to the instruction fetch/decode stage. It consumes decoded BEQ/JR/J instructions, the fetch prediction bit and register operand values, and resolves the actual control-flow outcome. On a wrong path it returns the mispredict/stall pulse and redirect PC to fetch, and squashes younger in-flight instructions for a fixed number of cycles. It also keeps saturating branch and mispredict statistics.

Parameters:
FLUSH_CYCLES, 2, cycles that flush_x70 stays asserted after a mispredict (legal range 1..15)
CNT_W, 16, width of the statistics counters

Ports:
clk_x70  input  1  clock; all state updates on the rising edge
rst_n_x70  input  1  reset, asynchronous, active-low
valid_in_x70  input  1  decoded instruction present this cycle
ready_x70  output  1  block accepts valid_in_x70; low while flushing
inst_type_x70  input  3  decoded type: 5=BEQ, 6=JR, 7=J, others are non-control
predicted_x70  input  1  fetch prediction for BEQ: 1=taken
pc_x70  input  32  byte PC of the instruction
imm_x70  input  32  sign-extended 16-bit immediate
src1_val_x70  input  32  value of source_1 register (rs)
src2_val_x70  input  32  value of source_2 register (rt)
mispredict_x70  output  1  one-cycle pulse to fetch (drives its prev_stalled input)
redirect_pc_x70  output  32  correct next PC; valid while mispredict_x70=1
flush_x70  output  1  squash younger pipeline stages
resolved_valid_x70  output  1  one-cycle pulse: a control instruction was resolved
resolved_taken_x70  output  1  actual outcome; qualified by resolved_valid_x70
branch_count_x70  output  CNT_W  resolved control instructions, saturating
mispredict_count_x70  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (asynchronous, rst_n_x70=0) forces every output and register to 0, except ready_x70, which is 1. The FSM goes to IDLE and the flush counter goes to 0.
- A reset asserted mid-flush aborts the flush immediately. No pending mispredict pulse survives reset.
- Pipeline:
  - Accept when valid_in_x70 && ready_x70 at edge N. Inputs are captured into an E1 register.
  - Resolution is combinational on E1. All outputs are registered, so results appear after edge N+1 (latency 1 cycle).
  - Throughput is one instruction per cycle while in IDLE.
- Arithmetic:
  - target = pc + 4 + (imm << 2), 32-bit two's complement with wrap; no overflow flag.
  - fallthrough = pc + 4, with wrap.
- BEQ (type 5):
  - Actual taken = (src1_val == src2_val).
  - If taken != predicted: pulse mispredict_x70, redirect_pc_x70 = taken ? target : fallthrough.
- JR (type 6):
  - Always taken, and fetch never predicts it, so it always mispredicts.
  - redirect_pc_x70 = {src1_val[31:2], 2'b00}.
- J (type 7):
  - Fetch already redirects J, so it is resolved taken with no mispredict.
- Other types (0..4):
  - No resolved_valid_x70 pulse, no counter update, no effect on the FSM.
- resolved_valid_x70 and resolved_taken_x70 pulse for exactly one cycle per resolved type 5/6/7.
- Counters:
  - branch_count_x70 increments on every resolved_valid_x70.
  - mispredict_count_x70 increments on every mispredict_x70.
  - Both hold at all-ones (2^CNT_W-1) and never wrap.
- FSM IDLE -> FLUSH: on a mispredict, in the same edge that raises mispredict_x70. Load flush counter = FLUSH_CYCLES. Set flush_x70=1 and ready_x70=0.
- FSM FLUSH:
  - Counter decrements each cycle; flush_x70 stays 1 for exactly FLUSH_CYCLES cycles.
  - valid_in_x70 is ignored and dropped: no capture, no counters, no pulses. The upstream holds or discards per ready_x70.
- FSM FLUSH -> IDLE: when the counter reaches 1, on the next edge ready_x70=1 and flush_x70=0.
- A second mispredict cannot occur during FLUSH, because nothing is accepted.
- mispredict_x70 never asserts twice within FLUSH_CYCLES+1 cycles.
- Back-to-back accepted BEQs resolve in order with no bubble until the first mispredict.

Test Plan:
1. Reset with pc=0, then BEQ with pc=8, imm=3, src1=src2=5, predicted=0. Required one cycle later: mispredict=1, redirect_pc=24, resolved_taken=1, flush=1 for 2 cycles, ready=0 for 2 cycles, both counters=1.
2. BEQ with pc=20, imm=-2 (0xFFFFFFFE), src1=1, src2=2, predicted=1. Required: mispredict=1, redirect_pc=24 (fallthrough); separately, the taken target for the same inputs computes as 16.
3. Four back-to-back correctly predicted BEQs. Required: 4 resolved_valid pulses on consecutive cycles, mispredict never asserted, branch_count=4, mispredict_count=0, ready stays 1.
4. JR with src1=0x0000003F, then J in the following cycle. Required: JR gives mispredict=1 and redirect_pc=0x3C; J arrives during flush and is dropped, so branch_count=1. J accepted after the flush gives resolved_taken=1 with no mispredict.
5. Mispredicting BEQ, then assert rst_n_x70=0 mid-flush (cycle 1 of 2). Required: flush=0, ready=1, and counters=0 immediately (asynchronous); after release, a fresh BEQ is accepted on the first edge.
6. With CNT_W=4, drive 17 mispredicting JRs, each spaced by the flush window. Required: mispredict_count saturates at 15 and branch_count saturates at 15.
